// File: rtl/counter_modulo.sv
// counter_modulo: up/down modulo counter with run-time step and bound.
//
// Counts within 0..max. Supports wrap (modulo max+1) or saturate at the
// bounds, a synchronous parallel load (clamped to max), a registered
// one-cycle wrap pulse and a sticky overflow flag.
//
// Ports:
//   clk      - clock, all state updates on posedge
//   rst      - asynchronous reset, active low
//   en       - count enable, one step per enabled cycle
//   up       - direction: 1 = increment, 0 = decrement
//   step     - step magnitude (zero-extended)
//   max      - inclusive upper bound
//   sat      - 1 = saturate at bounds, 0 = wrap
//   load     - synchronous load strobe (highest priority)
//   load_val - value to load, clamped to max
//   ovf_clr  - clears the sticky overflow flag (an event in the same cycle wins)
//   count    - registered count
//   wrap     - registered pulse: last update crossed a bound
//   ovf      - sticky: a bound crossing occurred since reset/clear
//   at_max   - combinational count == max
//   at_zero  - combinational count == 0
module counter_modulo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max,
  input  logic              sat,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              ovf,
  output logic              at_max,
  output logic              at_zero
);

  // One extra bit so sums and count+max+1 never truncate.
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   max_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   max_p1;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   next_x;
  logic [WIDTH-1:0] count_nxt;
  logic             event_nxt;

  always_comb begin
    cnt_x     = {1'b0, count};
    max_x     = {1'b0, max};
    step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    max_p1    = max_x + {{WIDTH{1'b0}}, 1'b1};
    sum       = cnt_x + step_x;
    next_x    = cnt_x;
    event_nxt = 1'b0;

    if (load) begin
      next_x = (load_val > max) ? max_x : {1'b0, load_val};
    end else if (en && (step_x != '0)) begin
      if (cnt_x > max_x) begin
        // Count left stranded above a lowered bound: snap back into range.
        event_nxt = 1'b1;
        next_x    = (up && !sat) ? '0 : max_x;
      end else if (up) begin
        if (sum > max_x) begin
          event_nxt = 1'b1;
          next_x    = sat ? max_x : (sum - max_p1);
        end else begin
          next_x = sum;
        end
      end else begin
        if (step_x > cnt_x) begin
          event_nxt = 1'b1;
          next_x    = sat ? '0 : (cnt_x + max_p1 - step_x);
        end else begin
          next_x = cnt_x - step_x;
        end
      end
    end

    // An illegal step (> max+1) may leave a result above max; it is simply
    // truncated here and recovered by the out-of-range path next step.
    count_nxt = next_x[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= event_nxt;
      ovf   <= event_nxt | (ovf & ~ovf_clr);
    end
  end

  assign at_max  = (count == max);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_counter_modulo.sv
// Self-checking bench for counter_modulo: directed test-plan sequences plus
// a constrained-random phase, checked through a scoreboard queue.
module tb_counter_modulo;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max;
  logic              sat;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              ovf_clr;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              ovf;
  logic              at_max;
  logic              at_zero;

  counter_modulo #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .step     (step),
    .max      (max),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .wrap     (wrap),
    .ovf      (ovf),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wr;
    bit ov;
    int mx;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the outcome, then compare after the edge.
  task automatic cyc(input bit ld, input int lv, input bit e, input bit u,
                     input int st, input int mx, input bit s, input bit oc);
    int   nc;
    bit   ev;
    exp_t ex;
    exp_t got;
    load     = ld;
    load_val = lv[WIDTH-1:0];
    en       = e;
    up       = u;
    step     = st[STEP_W-1:0];
    max      = mx[WIDTH-1:0];
    sat      = s;
    ovf_clr  = oc;

    nc = m_cnt;
    ev = 1'b0;
    if (ld) begin
      nc = (lv > mx) ? mx : lv;
    end else if (e && st != 0) begin
      if (m_cnt > mx) begin
        ev = 1'b1;
        if (u && !s) nc = 0;
        else         nc = mx;
      end else if (u) begin
        if (m_cnt + st > mx) begin
          ev = 1'b1;
          nc = s ? mx : (m_cnt + st - (mx + 1));
        end else begin
          nc = m_cnt + st;
        end
      end else begin
        if (st > m_cnt) begin
          ev = 1'b1;
          nc = s ? 0 : (m_cnt + (mx + 1) - st);
        end else begin
          nc = m_cnt - st;
        end
      end
    end
    m_cnt = nc;
    if (ev)      m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    ex.cnt = nc; ex.wr = ev; ex.ov = m_ovf; ex.mx = mx;
    sb.push_back(ex);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      check("count",   int'(count),   got.cnt);
      check("wrap",    int'(wrap),    int'(got.wr));
      check("ovf",     int'(ovf),     int'(got.ov));
      check("at_max",  int'(at_max),  int'(got.cnt == got.mx));
      check("at_zero", int'(at_zero), int'(got.cnt == 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; step = '0; max = '1; sat = 1'b0;
    load = 1'b0; load_val = '0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_ovf",   int'(ovf),   0);
    @(negedge clk);
    rst = 1'b1;

    // Modulo wrap up: max=9, step=3 from 0 -> 3,6,9,2
    cyc(1, 0, 0, 1, 0, 9, 0, 0);
    cyc(0, 0, 1, 1, 3, 9, 0, 0);  check("wu_3", int'(count), 3);
    cyc(0, 0, 1, 1, 3, 9, 0, 0);  check("wu_6", int'(count), 6);
    cyc(0, 0, 1, 1, 3, 9, 0, 0);  check("wu_9", int'(count), 9);
    check("wu_atmax", int'(at_max), 1);
    check("wu_nowrap", int'(wrap), 0);
    cyc(0, 0, 1, 1, 3, 9, 0, 0);  check("wu_2", int'(count), 2);
    check("wu_wrap", int'(wrap), 1);
    cyc(0, 0, 0, 1, 3, 9, 0, 0);  check("wu_ovf", int'(ovf), 1);
    check("wu_wrap_gone", int'(wrap), 0);

    // Asynchronous reset mid-count (count=37, ovf=1)
    cyc(1, 37, 0, 1, 0, 255, 0, 0); check("pre_rst", int'(count), 37);
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_wrap",  int'(wrap),  0);
    check("arst_ovf",   int'(ovf),   0);
    m_cnt = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 1, 1, 1, 255, 0, 0);
    cyc(0, 0, 1, 1, 1, 255, 0, 0);
    cyc(0, 0, 1, 1, 1, 255, 0, 0);  check("basic_3", int'(count), 3);

    // Wrap down then saturate
    cyc(1, 5, 0, 0, 4, 9, 0, 0);
    cyc(0, 0, 1, 0, 4, 9, 0, 0);  check("wd_1", int'(count), 1);
    cyc(0, 0, 1, 0, 4, 9, 0, 0);  check("wd_7", int'(count), 7);
    check("wd_wrap", int'(wrap), 1);
    cyc(1, 1, 0, 0, 4, 9, 1, 0);
    cyc(0, 0, 1, 0, 4, 9, 1, 0);  check("sat_0", int'(count), 0);
    check("sat_wrap", int'(wrap), 1);
    cyc(0, 0, 1, 0, 4, 9, 1, 0);  check("sat_pin", int'(count), 0);
    check("sat_pin_wrap", int'(wrap), 1);
    cyc(0, 0, 1, 0, 4, 9, 1, 0);

    // Load priority and clamp
    cyc(1, 200, 1, 1, 3, 100, 0, 0); check("ld_clamp", int'(count), 100);
    check("ld_nowrap", int'(wrap), 0);
    cyc(1, 50, 1, 1, 3, 100, 0, 0);  check("ld_50", int'(count), 50);

    // ovf clear, then clear racing an event
    cyc(0, 0, 0, 1, 0, 100, 0, 1);   check("ovf_clr", int'(ovf), 0);
    cyc(1, 8, 0, 1, 0, 9, 0, 0);
    cyc(0, 0, 1, 1, 3, 9, 0, 1);     check("race_cnt", int'(count), 1);
    check("race_ovf", int'(ovf), 1);

    // step=0 is a no-op even when enabled
    cyc(0, 0, 1, 1, 0, 9, 0, 0);     check("step0", int'(count), 1);
    check("step0_wrap", int'(wrap), 0);

    // max=0: every nonzero step is an event, count stays 0
    cyc(0, 0, 1, 1, 1, 0, 0, 0);     check("max0_a", int'(count), 0);
    cyc(0, 0, 1, 0, 1, 0, 0, 0);     check("max0_wrap", int'(wrap), 1);

    // Run-time max lowering
    cyc(1, 8, 0, 1, 0, 255, 0, 0);
    cyc(0, 0, 1, 1, 1, 5, 0, 0);     check("low_up", int'(count), 0);
    check("low_up_wrap", int'(wrap), 1);
    cyc(1, 8, 0, 1, 0, 255, 0, 0);
    cyc(0, 0, 1, 0, 1, 5, 0, 0);     check("low_dn", int'(count), 5);
    cyc(1, 8, 0, 1, 0, 255, 0, 0);
    cyc(0, 0, 1, 1, 1, 5, 1, 0);     check("low_up_sat", int'(count), 5);

    // Constrained random with legal steps
    begin
      int mx;
      mx = 20;
      for (int i = 0; i < 300; i++) begin
        int lim;
        if ($urandom_range(0, 7) == 0) mx = $urandom_range(0, 255);
        lim = (mx + 1 > 15) ? 15 : mx + 1;
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, lim), mx, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_modulo.md
Name: counter_modulo

Overview:
Parametrised successor to the team's basic enable counter. Supports the following:
- Up/down counting with a run-time step size.
- A run-time modulus (upper bound).
- Selectable wrap or saturate behaviour at the bounds.
- Synchronous parallel load.
- Registered wrap pulse and a sticky overflow flag.

It is used as a general-purpose event, address and timer counter across the lab datapaths.

Parameters:
- WIDTH, 8, count/bound/load width in bits (>= 2).
- STEP_W, 4, step input width in bits (1 <= STEP_W <= WIDTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- step  input  STEP_W  step magnitude, zero-extended to WIDTH.
- max  input  WIDTH  inclusive upper bound; legal range is 0..max.
- sat  input  1  bound mode: 1 = saturate, 0 = wrap (modulo max+1).
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- ovf_clr  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count (registered).
- wrap  output  1  registered one-cycle pulse: the last update crossed a bound.
- ovf  output  1  sticky: a bound crossing has occurred since reset/clear.
- at_max  output  1  combinational, count == max.
- at_zero  output  1  combinational, count == 0.

Behaviour:
- Reset: rst=0 asynchronously forces count=0, wrap=0, ovf=0. Release is synchronised by the integrator upstream; the block clears immediately on rst falling regardless of clk.
- Priority each posedge: load > en > hold.
- Load: count <= (load_val > max) ? max : load_val. wrap <= 0. ovf unchanged. Load ignores en, up, step.
- Hold: when en=0 and load=0, count holds and wrap <= 0.
- step=0 with en=1: count unchanged, wrap <= 0.
- Arithmetic is evaluated in WIDTH+1 bits, so no intermediate truncation.
- Up, count <= max: s = count + step.
  - If s <= max: count <= s, no event.
  - Else, wrap mode: count <= s - (max+1). Saturate mode: count <= max. Either mode raises an event.
- Down, count <= max:
  - If step <= count: count <= count - step, no event.
  - Else, wrap mode: count <= count + (max+1) - step. Saturate mode: count <= 0. Either mode raises an event.
- Out-of-range count (count > max, reachable only after max is lowered at run time), on an enabled step:
  - Up: count <= 0 in wrap mode, max in saturate mode.
  - Down: count <= max.
  - Either direction raises an event.
- Step legality: step > max+1 is illegal. The bench must not drive it; the resulting count is unspecified, but the RTL must not hang.
- Event handling:
  - wrap <= 1 for exactly the cycle following the update, coincident with the new count value.
  - ovf <= 1.
  - A saturate-mode event also raises wrap and ovf, even when count does not change (already pinned at a bound).
- ovf_clr: clears ovf at posedge. If an event occurs in the same cycle, set wins and ovf stays 1.
- max=0: the only legal value is 0. Every enabled step with step>0 raises an event; count stays 0.
- Run-time changes: max, sat and up may change on any cycle and take effect at the next posedge.
- Latency: count/wrap/ovf update one cycle after the sampled inputs. at_max and at_zero follow count combinationally.

Test Plan:
- Reset/basic: rst=0 mid-count (count=37) -> count=0, wrap=0, ovf=0 immediately without clk. Release, en=1, up=1, step=1, max=255, 3 cycles -> count=3.
- Modulo wrap up: max=9, step=3, from 0 -> 3, 6, 9, 2. wrap=1 only alongside the 2; ovf=1 thereafter; at_max=1 when count=9.
- Wrap down + saturate: max=9, up=0, step=4, from 5 -> 1, 7 (wrap=1). Then sat=1, load 1, step=4 -> 0 (wrap=1), then stays 0 with wrap=1 on each enabled cycle.
- Load priority/clamp: load=1, en=1, load_val=200, max=100 -> count=100, wrap=0. load_val=50 -> count=50.
- ovf clear race: ovf=1, pulse ovf_clr with no event -> ovf=0. ovf_clr in the same cycle as a wrap event -> ovf=1.
- Run-time max lowering: count=8, set max=5, up=1, step=1 -> count=0, wrap=1 (wrap mode). Repeat with up=0 -> count=5.
